// File: rtl/alu_result_buffer.sv
// ALU result FIFO: stores {result, flags, control} per accepted result and tracks sticky overflow/carry.
// Latency: an entry pushed at edge N is at the head from edge N (no bypass); backpressure: in_ready=0 when full.
module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_less,
    input  logic             in_equal,
    input  logic             in_zero,
    input  logic             in_over,
    input  logic             in_carry,
    input  logic [4:0]       in_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [4:0]       out_flags,
    output logic [4:0]       out_control,
    output logic [PTR_W:0]   count,
    output logic             sticky_over,
    output logic             sticky_carry,
    input  logic             clear_sticky
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0]      result_q  [DEPTH];
    logic [4:0]       flags_q   [DEPTH];
    logic [4:0]       control_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             sticky_over_q, sticky_over_d;
    logic             sticky_carry_q, sticky_carry_d;
    logic             push, pop;
    logic [4:0]       in_flags;

    assign in_flags  = {in_carry, in_over, in_zero, in_equal, in_less};
    assign in_ready  = (count_q != DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_result   = result_q[rd_ptr_q];
    assign out_flags    = flags_q[rd_ptr_q];
    assign out_control  = control_q[rd_ptr_q];
    assign count        = count_q;
    assign sticky_over  = sticky_over_q;
    assign sticky_carry = sticky_carry_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        // A same-cycle event wins over clear so it is never lost.
        sticky_over_d  = (sticky_over_q  && !clear_sticky) || (push && in_over);
        sticky_carry_d = (sticky_carry_q && !clear_sticky) || (push && in_carry);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            sticky_over_q  <= 1'b0;
            sticky_carry_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                result_q[i]  <= '0;
                flags_q[i]   <= '0;
                control_q[i] <= '0;
            end
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            sticky_over_q  <= sticky_over_d;
            sticky_carry_q <= sticky_carry_d;
            if (push) begin
                result_q[wr_ptr_q]  <= in_result;
                flags_q[wr_ptr_q]   <= in_flags;
                control_q[wr_ptr_q] <= in_control;
            end
        end
    end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream stage of the ALU: registers each ALU result, its five status flags and the 5-bit control code that produced it into a small FIFO. The FIFO is presented to the writeback/consumer side through a valid/ready handshake. It also keeps sticky overflow and carry status bits for software-visible exception reporting. It decouples the combinational ALU from a consumer that can stall.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous reset, active-high; clears all state immediately.
- in_valid  input  1  ALU side presents a result this cycle.
- in_ready  output  1  buffer can accept; equals (count < DEPTH).
- in_result  input  32  ALU result word.
- in_less, in_equal, in_zero, in_over, in_carry  input  1 each  ALU flags.
- in_control  input  5  ALU control code; stored as a tag.
- out_valid  output  1  head entry is present; equals (count != 0).
- out_ready  input  1  consumer takes the head entry this cycle.
- out_result  output  32  head entry result.
- out_flags  output  5  head entry flags packed {carry, over, zero, equal, less}.
- out_control  output  5  head entry control tag.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.
- sticky_over  output  1  set when any accepted entry had in_over=1.
- sticky_carry  output  1  set when any accepted entry had in_carry=1.
- clear_sticky  input  1  synchronous clear of both sticky bits.

## Operation
- Push: occurs when in_valid && in_ready. The entry {in_result, flags, in_control} is written at wr_ptr, and wr_ptr advances by 1 modulo DEPTH.
- Pop: occurs when out_valid && out_ready. rd_ptr advances by 1 modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged.
  - neither: unchanged.
- Full (count == DEPTH):
  - in_ready=0, and in_valid is ignored even if a pop happens the same cycle. There is no full-bypass.
  - The upstream source holds its data until in_ready returns.
- Empty (count == 0):
  - out_valid=0 and out_ready is ignored.
  - out_* fields show the storage at rd_ptr, which is don't-care for the consumer.
  - There is no empty-bypass: a pushed entry is never visible in the same cycle it is pushed.
- Pointer wrap: pointers are PTR_W bits and wrap naturally. Full and empty are distinguished by count, not by the pointers.
- Sticky bits:
  - On an accepted push, sticky_over |= in_over and sticky_carry |= in_carry.
  - clear_sticky=1 clears both bits at the next edge.
  - If clear_sticky and a setting push occur in the same cycle, the bit ends at 1 (a new event is never lost).
  - A non-accepted in_valid (full) never sets the sticky bits.
- Data-path is pure storage; no arithmetic is performed on result or flags.
- Reset (asynchronous, any time, including mid-transfer):
  - count=0, wr_ptr=rd_ptr=0, all storage=0, sticky bits=0.
  - Hence in_ready=1, out_valid=0, out_result=0, out_flags=0, out_control=0.
  - Entries in flight are discarded.

## Timing
- in_ready, out_valid and count are derived from registered state only. None of them has a combinational path from in_valid or out_ready.
- out_result, out_flags and out_control are combinational reads of registered storage at rd_ptr. They are stable for the whole cycle.
- Latency: a push at edge N gives out_valid=1 with that entry at the head from edge N onward, i.e. visible in cycle N+1 if the FIFO was empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- When out_valid=1 and out_ready=0, the head entry holds stable until popped. Its contents never change while it is valid.
- Reset deassertion: the first push is accepted at the first rising edge after rst falls.

## Test plan
- Reset, then push A: result=0x0000_0005, control=5'd2, flags zero=0, carry=1. Required: out_valid=1 next cycle, out_result=0x5, out_flags=5'b10000, out_control=2, sticky_carry=1, count=1.
- Push 4 entries with out_ready=0. Required: count=4, in_ready=0. Then assert a fifth in_valid with over=1. Required: the entry is not stored, sticky_over stays 0, and count stays 4.
- From count=4, set out_ready=1 for 4 cycles. Required: entries pop in push order (values 1, 2, 3, 4), count returns to 0, and out_valid=0.
- Run 10 cycles of simultaneous push and pop with count=2. Required: count stays 2, pointers wrap past 3→0, and output order is preserved.
- Push an entry with over=1 in the same cycle as clear_sticky=1. Required: sticky_over=1. Next cycle, clear_sticky=1 with no push. Required: sticky_over=0.
- Assert rst asynchronously, mid-cycle, with count=3. Required: immediately count=0, out_valid=0, in_ready=1, out_result=0, and sticky bits=0.
